// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates IDs, captures CDB results,
// forwards operands and retires one entry per cycle with mispredict rollback.
module reorder_buffer #(
    parameter int ROB_SIZE = 16,
    parameter int ROB_ID_W = 5
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                rdy_in,
    input  logic                alloc_valid_in,
    input  logic [4:0]          alloc_rd_in,
    output logic [ROB_ID_W-1:0] alloc_rob_id_out,
    output logic                rob_full_out,
    input  logic                cdb_valid_in,
    input  logic [ROB_ID_W-1:0] cdb_rob_id_in,
    input  logic [31:0]         cdb_value_in,
    input  logic                cdb_mispredict_in,
    input  logic [31:0]         cdb_redirect_pc_in,
    input  logic [ROB_ID_W-1:0] q1_rob_id_in,
    input  logic [ROB_ID_W-1:0] q2_rob_id_in,
    output logic                q1_ready_out,
    output logic [31:0]         q1_value_out,
    output logic                q2_ready_out,
    output logic [31:0]         q2_value_out,
    output logic                commit_flag_out,
    output logic [4:0]          commit_rd_out,
    output logic [31:0]         commit_value_out,
    output logic [ROB_ID_W-1:0] commit_rob_id_out,
    output logic                rollback_flag_out,
    output logic [31:0]         rollback_pc_out
);
    localparam int IDX_W = $clog2(ROB_SIZE);
    localparam int CNT_W = IDX_W + 1;

    logic [IDX_W-1:0]    head, tail;
    logic [CNT_W-1:0]    count;
    logic [ROB_SIZE-1:0] busy, ready, mispredict;
    logic [4:0]          rd_q       [ROB_SIZE];
    logic [31:0]         value_q    [ROB_SIZE];
    logic [31:0]         redirect_q [ROB_SIZE];

    // IDs are slot + 1 so that ID 0 can mean "no producer".
    function automatic logic [IDX_W-1:0] slot_of(input logic [ROB_ID_W-1:0] id);
        return IDX_W'(id - ROB_ID_W'(1));
    endfunction

    function automatic logic id_ok(input logic [ROB_ID_W-1:0] id);
        return (id != '0) && (id <= ROB_ID_W'(ROB_SIZE));
    endfunction

    logic             do_commit, do_flush, do_alloc, cdb_hit;
    logic [IDX_W-1:0] cdb_slot, q1_slot, q2_slot;

    assign alloc_rob_id_out = ROB_ID_W'(tail) + ROB_ID_W'(1);
    assign rob_full_out     = (count == CNT_W'(ROB_SIZE));

    assign cdb_slot  = slot_of(cdb_rob_id_in);
    assign q1_slot   = slot_of(q1_rob_id_in);
    assign q2_slot   = slot_of(q2_rob_id_in);
    assign do_commit = busy[head] && ready[head];
    assign do_flush  = do_commit && mispredict[head];
    assign do_alloc  = alloc_valid_in && !rob_full_out;
    assign cdb_hit   = cdb_valid_in && id_ok(cdb_rob_id_in) && busy[cdb_slot];

    always_comb begin
        q1_ready_out = 1'b0;
        q1_value_out = '0;
        if (q1_rob_id_in == '0) begin
            q1_ready_out = 1'b1;
        end else if (cdb_valid_in && cdb_rob_id_in == q1_rob_id_in) begin
            q1_ready_out = 1'b1;
            q1_value_out = cdb_value_in;
        end else if (id_ok(q1_rob_id_in) && busy[q1_slot] && ready[q1_slot]) begin
            q1_ready_out = 1'b1;
            q1_value_out = value_q[q1_slot];
        end
    end

    always_comb begin
        q2_ready_out = 1'b0;
        q2_value_out = '0;
        if (q2_rob_id_in == '0) begin
            q2_ready_out = 1'b1;
        end else if (cdb_valid_in && cdb_rob_id_in == q2_rob_id_in) begin
            q2_ready_out = 1'b1;
            q2_value_out = cdb_value_in;
        end else if (id_ok(q2_rob_id_in) && busy[q2_slot] && ready[q2_slot]) begin
            q2_ready_out = 1'b1;
            q2_value_out = value_q[q2_slot];
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head              <= '0;
            tail              <= '0;
            count             <= '0;
            busy              <= '0;
            ready             <= '0;
            mispredict        <= '0;
            commit_flag_out   <= 1'b0;
            commit_rd_out     <= '0;
            commit_value_out  <= '0;
            commit_rob_id_out <= '0;
            rollback_flag_out <= 1'b0;
            rollback_pc_out   <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                rd_q[i]       <= '0;
                value_q[i]    <= '0;
                redirect_q[i] <= '0;
            end
        end else if (!rdy_in || rollback_flag_out) begin
            // Frozen, or the flush cycle: inputs ignored, pulses drop.
            commit_flag_out   <= 1'b0;
            rollback_flag_out <= 1'b0;
        end else begin
            commit_flag_out   <= do_commit;
            rollback_flag_out <= do_flush;
            if (cdb_hit) begin
                ready[cdb_slot]      <= 1'b1;
                value_q[cdb_slot]    <= cdb_value_in;
                mispredict[cdb_slot] <= cdb_mispredict_in;
                redirect_q[cdb_slot] <= cdb_redirect_pc_in;
            end
            if (do_alloc) begin
                busy[tail]       <= 1'b1;
                ready[tail]      <= 1'b0;
                mispredict[tail] <= 1'b0;
                rd_q[tail]       <= alloc_rd_in;
                tail             <= tail + 1'b1;
            end
            if (do_commit) begin
                commit_rd_out     <= rd_q[head];
                commit_value_out  <= value_q[head];
                commit_rob_id_out <= ROB_ID_W'(head) + ROB_ID_W'(1);
                busy[head]        <= 1'b0;
                ready[head]       <= 1'b0;
                head              <= head + 1'b1;
            end
            case ({do_alloc, do_commit})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Later assignments override the bookkeeping above on a flush.
            if (do_flush) begin
                busy            <= '0;
                ready           <= '0;
                mispredict      <= '0;
                head            <= '0;
                tail            <= '0;
                count           <= '0;
                rollback_pc_out <= redirect_q[head];
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: expected retirements are queued when
// results are broadcast and popped when the commit pulse appears.
module tb_reorder_buffer;
    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        alloc_valid_in = 1'b0;
    logic [4:0]  alloc_rd_in = '0;
    logic [4:0]  alloc_rob_id_out;
    logic        rob_full_out;
    logic        cdb_valid_in = 1'b0;
    logic [4:0]  cdb_rob_id_in = '0;
    logic [31:0] cdb_value_in = '0;
    logic        cdb_mispredict_in = 1'b0;
    logic [31:0] cdb_redirect_pc_in = '0;
    logic [4:0]  q1_rob_id_in = '0, q2_rob_id_in = '0;
    logic        q1_ready_out, q2_ready_out;
    logic [31:0] q1_value_out, q2_value_out;
    logic        commit_flag_out;
    logic [4:0]  commit_rd_out;
    logic [31:0] commit_value_out;
    logic [4:0]  commit_rob_id_out;
    logic        rollback_flag_out;
    logic [31:0] rollback_pc_out;

    reorder_buffer #(.ROB_SIZE(16), .ROB_ID_W(5)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
        .alloc_valid_in(alloc_valid_in), .alloc_rd_in(alloc_rd_in),
        .alloc_rob_id_out(alloc_rob_id_out), .rob_full_out(rob_full_out),
        .cdb_valid_in(cdb_valid_in), .cdb_rob_id_in(cdb_rob_id_in),
        .cdb_value_in(cdb_value_in), .cdb_mispredict_in(cdb_mispredict_in),
        .cdb_redirect_pc_in(cdb_redirect_pc_in),
        .q1_rob_id_in(q1_rob_id_in), .q2_rob_id_in(q2_rob_id_in),
        .q1_ready_out(q1_ready_out), .q1_value_out(q1_value_out),
        .q2_ready_out(q2_ready_out), .q2_value_out(q2_value_out),
        .commit_flag_out(commit_flag_out), .commit_rd_out(commit_rd_out),
        .commit_value_out(commit_value_out), .commit_rob_id_out(commit_rob_id_out),
        .rollback_flag_out(rollback_flag_out), .rollback_pc_out(rollback_pc_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] value;
        logic [4:0]  id;
        logic        rb;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [75:0] obs();
        return {commit_flag_out, commit_rd_out, commit_value_out,
                commit_rob_id_out, rollback_flag_out, rollback_pc_out};
    endfunction

    task automatic cycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        alloc_valid_in = 0; cdb_valid_in = 0; rdy_in = 1;
        cdb_mispredict_in = 0; cdb_redirect_pc_in = '0;
        q1_rob_id_in = '0; q2_rob_id_in = '0;
        rst_n_in = 0;
        @(negedge clk_in);
        rst_n_in = 1;
        cycle();
        sb.delete();
    endtask

    task automatic alloc(input logic [4:0] rd);
        alloc_valid_in = 1; alloc_rd_in = rd;
        cycle();
        alloc_valid_in = 0;
    endtask

    task automatic cdb(input logic [4:0] id, input logic [31:0] val,
                       input logic mp, input logic [31:0] pc);
        cdb_valid_in = 1; cdb_rob_id_in = id; cdb_value_in = val;
        cdb_mispredict_in = mp; cdb_redirect_pc_in = pc;
        cycle();
        cdb_valid_in = 0; cdb_mispredict_in = 0;
    endtask

    task automatic test_reset();
        rst_n_in = 0;
        #2;
        n_vec++;
        if (obs() !== 76'd0) begin
            n_err++; $display("FAIL reset_regs got %h want 0", obs());
        end
        n_vec++;
        if ({alloc_rob_id_out, rob_full_out} !== {5'd1, 1'b0}) begin
            n_err++; $display("FAIL reset_alloc got id=%0d full=%0b want id=1 full=0",
                              alloc_rob_id_out, rob_full_out);
        end
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        alloc(5'd5);
        cdb(5'd1, 32'h1234, 1'b0, 32'h0);
        sb.push_back('{rd: 5'd5, value: 32'h1234, id: 5'd1, rb: 1'b0, pc: 32'h0});
        n_vec++;
        if (commit_flag_out !== 1'b0) begin
            n_err++; $display("FAIL basic_early_commit got %0b want 0", commit_flag_out);
        end
        cycle();
        e = sb.pop_front();
        n_vec++;
        if (obs() !== {1'b1, e}) begin
            n_err++; $display("FAIL basic_commit got %h want %h", obs(), {1'b1, e});
        end
        cycle();
        n_vec++;
        if ({commit_flag_out, dut.count} !== {1'b0, 5'd0}) begin
            n_err++; $display("FAIL basic_drain got flag=%0b count=%0d want 0 0",
                              commit_flag_out, dut.count);
        end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 16; i++) alloc(5'(i + 1));
        n_vec++;
        if ({rob_full_out, alloc_rob_id_out} !== {1'b1, 5'd1}) begin
            n_err++; $display("FAIL full_set got full=%0b id=%0d want 1 1",
                              rob_full_out, alloc_rob_id_out);
        end
        alloc(5'd30);
        n_vec++;
        if ({alloc_rob_id_out, dut.count} !== {5'd1, 5'd16}) begin
            n_err++; $display("FAIL full_drop got id=%0d count=%0d want 1 16",
                              alloc_rob_id_out, dut.count);
        end
        cdb(5'd1, 32'hC0DE0001, 1'b0, 32'h0);
        sb.push_back('{rd: 5'd1, value: 32'hC0DE0001, id: 5'd1, rb: 1'b0, pc: 32'h0});
        alloc_valid_in = 1; alloc_rd_in = 5'd9;
        cycle();
        e = sb.pop_front();
        n_vec++;
        if (obs() !== {1'b1, e}) begin
            n_err++; $display("FAIL full_commit got %h want %h", obs(), {1'b1, e});
        end
        n_vec++;
        if ({rob_full_out, alloc_rob_id_out} !== {1'b0, 5'd1}) begin
            n_err++; $display("FAIL full_refuse got full=%0b id=%0d want 0 1",
                              rob_full_out, alloc_rob_id_out);
        end
        cycle();
        alloc_valid_in = 0;
        n_vec++;
        if ({rob_full_out, alloc_rob_id_out, dut.count} !== {1'b1, 5'd2, 5'd16}) begin
            n_err++; $display("FAIL wrap_alloc got full=%0b id=%0d count=%0d want 1 2 16",
                              rob_full_out, alloc_rob_id_out, dut.count);
        end
    endtask

    task automatic test_out_of_order();
        do_reset();
        for (int i = 1; i <= 3; i++) alloc(5'(i));
        cdb(5'd3, 32'h33, 1'b0, 32'h0);
        cycle();
        n_vec++;
        if (commit_flag_out !== 1'b0) begin
            n_err++; $display("FAIL ooo_hold got %0b want 0", commit_flag_out);
        end
        sb.push_back('{rd: 5'd1, value: 32'h11, id: 5'd1, rb: 1'b0, pc: 32'h0});
        sb.push_back('{rd: 5'd2, value: 32'h22, id: 5'd2, rb: 1'b0, pc: 32'h0});
        sb.push_back('{rd: 5'd3, value: 32'h33, id: 5'd3, rb: 1'b0, pc: 32'h0});
        cdb(5'd1, 32'h11, 1'b0, 32'h0);
        n_vec++;
        if (commit_flag_out !== 1'b0) begin
            n_err++; $display("FAIL ooo_id1_latency got %0b want 0", commit_flag_out);
        end
        cdb(5'd2, 32'h22, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            if (k != 0) cycle();
            e = sb.pop_front();
            n_vec++;
            if (obs() !== {1'b1, e}) begin
                n_err++; $display("FAIL ooo_commit%0d got %h want %h", k + 1, obs(), {1'b1, e});
            end
        end
    endtask

    task automatic test_mispredict();
        do_reset();
        for (int i = 0; i < 4; i++) alloc(5'(10 + i));
        cdb(5'd2, 32'h44, 1'b1, 32'h200);
        sb.push_back('{rd: 5'd10, value: 32'h11, id: 5'd1, rb: 1'b0, pc: 32'h0});
        sb.push_back('{rd: 5'd11, value: 32'h44, id: 5'd2, rb: 1'b1, pc: 32'h200});
        cdb(5'd1, 32'h11, 1'b0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            cycle();
            e = sb.pop_front();
            n_vec++;
            if (obs() !== {1'b1, e}) begin
                n_err++; $display("FAIL mp_commit%0d got %h want %h", k + 1, obs(), {1'b1, e});
            end
        end
        n_vec++;
        if ({alloc_rob_id_out, dut.count, rob_full_out} !== {5'd1, 5'd0, 1'b0}) begin
            n_err++; $display("FAIL mp_empty got id=%0d count=%0d want 1 0",
                              alloc_rob_id_out, dut.count);
        end
        alloc_valid_in = 1; alloc_rd_in = 5'd20;
        cdb(5'd3, 32'h99, 1'b0, 32'h0);
        n_vec++;
        if ({commit_flag_out, rollback_flag_out, alloc_rob_id_out} !== {1'b0, 1'b0, 5'd1}) begin
            n_err++; $display("FAIL mp_flush_cycle got c=%0b rb=%0b id=%0d want 0 0 1",
                              commit_flag_out, rollback_flag_out, alloc_rob_id_out);
        end
        cycle();
        alloc_valid_in = 0;
        n_vec++;
        if ({alloc_rob_id_out, dut.count} !== {5'd2, 5'd1}) begin
            n_err++; $display("FAIL mp_realloc got id=%0d count=%0d want 2 1",
                              alloc_rob_id_out, dut.count);
        end
    endtask

    task automatic test_query();
        do_reset();
        for (int i = 0; i < 4; i++) alloc(5'(i + 1));
        cdb_valid_in = 1; cdb_rob_id_in = 5'd4; cdb_value_in = 32'hAB;
        q1_rob_id_in = 5'd4; q2_rob_id_in = 5'd0;
        #1;
        n_vec++;
        if ({q1_ready_out, q1_value_out} !== {1'b1, 32'hAB}) begin
            n_err++; $display("FAIL q_bypass got r=%0b v=%h want 1 ab", q1_ready_out, q1_value_out);
        end
        n_vec++;
        if ({q2_ready_out, q2_value_out} !== {1'b1, 32'h0}) begin
            n_err++; $display("FAIL q_zero got r=%0b v=%h want 1 0", q2_ready_out, q2_value_out);
        end
        q2_rob_id_in = 5'd3;
        #1;
        n_vec++;
        if ({q2_ready_out, q2_value_out} !== {1'b0, 32'h0}) begin
            n_err++; $display("FAIL q_pending got r=%0b v=%h want 0 0", q2_ready_out, q2_value_out);
        end
        cycle();
        cdb_valid_in = 0;
        #1;
        n_vec++;
        if ({q1_ready_out, q1_value_out} !== {1'b1, 32'hAB}) begin
            n_err++; $display("FAIL q_stored got r=%0b v=%h want 1 ab", q1_ready_out, q1_value_out);
        end
    endtask

    task automatic test_rdy_and_async_reset();
        do_reset();
        alloc(5'd6);
        cdb(5'd1, 32'h66, 1'b0, 32'h0);
        sb.push_back('{rd: 5'd6, value: 32'h66, id: 5'd1, rb: 1'b0, pc: 32'h0});
        rdy_in = 0; alloc_valid_in = 1; alloc_rd_in = 5'd8;
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_vec++;
            if (commit_flag_out !== 1'b0) begin
                n_err++; $display("FAIL rdy_hold%0d got %0b want 0", k, commit_flag_out);
            end
        end
        n_vec++;
        if ({alloc_rob_id_out, dut.count} !== {5'd2, 5'd1}) begin
            n_err++; $display("FAIL rdy_frozen got id=%0d count=%0d want 2 1",
                              alloc_rob_id_out, dut.count);
        end
        alloc_valid_in = 0; rdy_in = 1;
        cycle();
        e = sb.pop_front();
        n_vec++;
        if (obs() !== {1'b1, e}) begin
            n_err++; $display("FAIL rdy_resume got %h want %h", obs(), {1'b1, e});
        end
        alloc(5'd7);
        cdb(5'd2, 32'h77, 1'b0, 32'h0);
        sb.push_back('{rd: 5'd7, value: 32'h77, id: 5'd2, rb: 1'b0, pc: 32'h0});
        cycle();
        e = sb.pop_front();
        n_vec++;
        if (obs() !== {1'b1, e}) begin
            n_err++; $display("FAIL pre_reset_commit got %h want %h", obs(), {1'b1, e});
        end
        rst_n_in = 0;
        #2;
        n_vec++;
        if ({obs(), alloc_rob_id_out, rob_full_out} !== {76'd0, 5'd1, 1'b0}) begin
            n_err++; $display("FAIL async_reset got %h id=%0d want 0 1", obs(), alloc_rob_id_out);
        end
        @(negedge clk_in);
        rst_n_in = 1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_wrap();
        test_out_of_order();
        test_mispredict();
        test_query();
        test_rdy_and_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order reorder buffer for the Tomasulo core.
- Allocates ROB IDs to the dispatcher and captures results broadcast on the CDB.
- Answers operand-forwarding queries.
- Retires one instruction per cycle to the register file (commit flag, rd, value, ROB ID), and raises the global rollback on a retiring mispredicted branch.

Parameters:
- ROB_SIZE, 16, number of entries (power of two).
- ROB_ID_W, 5, ROB ID width; ID = slot index + 1; ID 0 means "no producer / ready".

Ports:
- clk_in  input  1  clock.
- rst_n_in  input  1  reset, asynchronous, active-low.
- rdy_in  input  1  global ready; low freezes all state.
- alloc_valid_in  input  1  dispatcher allocates an entry this cycle.
- alloc_rd_in  input  5  destination register (0 = none).
- alloc_rob_id_out  output  ROB_ID_W  ID the next allocation receives (tail+1), combinational.
- rob_full_out  output  1  count == ROB_SIZE.
- cdb_valid_in  input  1  result broadcast valid.
- cdb_rob_id_in  input  ROB_ID_W  producing entry.
- cdb_value_in  input  32  result value.
- cdb_mispredict_in  input  1  branch resolved against prediction.
- cdb_redirect_pc_in  input  32  correct PC when mispredicted.
- q1_rob_id_in, q2_rob_id_in  input  ROB_ID_W  operand queries.
- q1_ready_out, q2_ready_out  output  1  value available, combinational.
- q1_value_out, q2_value_out  output  32  forwarded value, combinational.
- commit_flag_out  output  1  one-cycle retire pulse.
- commit_rd_out  output  5  retired destination.
- commit_value_out  output  32  retired value.
- commit_rob_id_out  output  ROB_ID_W  retired entry ID (register file clears its tag only if it matches).
- rollback_flag_out  output  1  one-cycle flush pulse.
- rollback_pc_out  output  32  fetch redirect target.

Behaviour:
- Reset (async, rst_n_in=0):
  - head=tail=count=0; all entries not busy.
  - All registered outputs 0; alloc_rob_id_out=1; rob_full_out=0.
- Per entry: busy, ready, rd, value, mispredict, redirect_pc.
- Allocation: on a clock edge with rdy_in && alloc_valid_in && !rob_full_out && !rollback_flag_out:
  - entry[tail] gets busy=1, ready=0, rd=alloc_rd_in, mispredict=0.
  - tail wraps modulo ROB_SIZE.
  - Allocation while full is dropped silently; the dispatcher must stall on rob_full_out.
- CDB capture: cdb_valid_in with a nonzero ID of a busy entry sets ready=1 and latches value, mispredict and redirect_pc. ID 0, or an ID of a non-busy entry, is ignored.
- Commit: when entry[head] is busy && ready, at that edge:
  - commit_flag_out<=1, with rd/value/rob_id of the head entry.
  - entry cleared; head advances.
  - Otherwise commit_flag_out<=0.
  - At most one commit per cycle.
  - A CDB write to the head entry commits no earlier than the next edge (ready is registered).
- Mispredict: when the committing entry has mispredict=1, at the same edge:
  - the commit pulse still occurs (JAL/JALR rd is written);
  - rollback_flag_out<=1 and rollback_pc_out<=redirect_pc;
  - all entries are cleared; head=tail=count=0;
  - any allocation at that edge is dropped.
  - During the cycle rollback_flag_out=1, alloc and CDB inputs are ignored; no commit occurs.
- Count:
  - alloc only: +1; commit only: −1; alloc and commit together: unchanged.
  - rob_full_out derives from the registered count, so alloc is refused while full even when a commit happens that cycle.
- Query (per port):
  - ID 0: ready=1, value=0.
  - Else, if cdb_valid_in && cdb_rob_id_in==ID: ready=1, value=cdb_value_in (bypass).
  - Else if entry busy && ready: ready=1, entry value.
  - Else: ready=0, value=0.
- rdy_in=0: no state change; commit_flag_out and rollback_flag_out are forced 0 at that edge.
- Wrap-around: IDs reuse slots after head passes; head==tail is disambiguated by count.

Test Plan:
- Reset, allocate rd=5, CDB ID1 value 0x1234 -> the next edge has no commit; the following edge gives commit_flag=1, rd=5, value=0x1234, rob_id=1; count returns to 0.
- Fill 16 entries -> rob_full_out=1; a 17th alloc is dropped (tail unchanged). Complete ID1; the commit edge with alloc asserted still refuses the alloc; the next cycle the alloc succeeds with ID 1 (wrap).
- Complete ID3 before IDs 1 and 2 -> no commit until ID1 is ready; then IDs 1, 2, 3 retire on consecutive cycles in order.
- Entries 1–4; ID2 completes with mispredict=1, redirect 0x200 -> ID1 commits, then ID2 commits with rollback_flag=1 and rollback_pc=0x200; the ROB is empty and the next alloc gets ID 1.
- Query ID4 while CDB broadcasts ID4 value 0xAB -> ready=1, value 0xAB the same cycle; query ID 0 -> ready=1, value 0.
- Hold rdy_in=0 with the head ready -> no commit, state frozen; restoring rdy_in commits at the next edge. Drive rst_n_in low mid-stream -> outputs clear immediately, without a clock edge.
